// File: rtl/e1of4_tb_pkg.sv
// ============================================================================
// Module : e1of4_tb_pkg
// Brief  : Shared encodings for the e1of4 register tester.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package e1of4_tb_pkg;

    localparam logic [1:0] CTRL_READ  = 2'b00;
    localparam logic [1:0] CTRL_WRITE = 2'b01;
    localparam logic [1:0] CTRL_RDWR  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 with a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    function automatic logic cmd_reads(input logic [1:0] ctrl);
        return (ctrl == CTRL_READ) || (ctrl == CTRL_RDWR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e1of4_tester_exp_fifo.sv
// ============================================================================
// Module : e1of4_tester_exp_fifo
// Brief  : Synchronous FIFO of expected read values; push+pop allowed when full.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module e1of4_tester_exp_fifo #(
    parameter int DW    = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/e1of4_reg_tester.sv
// ============================================================================
// Module : e1of4_reg_tester
// Brief  : Command generator and read checker for e1of4 QDI register DUTs.
//          Optional watchdog enabled by defining TESTER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module e1of4_reg_tester
    import e1of4_tb_pkg::*;
#(
    parameter int DW         = 2,
    parameter int NUM_TOKENS = 16,
    parameter int MODE       = 0,
    parameter int INIT_VAL   = 0,
    parameter int EXP_DEPTH  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    output logic [DW-1:0] tx_data,
    output logic [1:0]    tx_ctrl,
    output logic          tx_go,
    input  logic          tx_ack,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          busy,
    output logic          done,
    output logic [15:0]   tx_count,
    output logic [15:0]   rx_count,
    output logic [15:0]   err_count,
    output logic          timeout
);

    localparam logic [31:0] NUM_TOK_U = 32'(NUM_TOKENS);

    if ((DW % 2) != 0 || DW < 2 || NUM_TOKENS < 1 || EXP_DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("e1of4_reg_tester: illegal parameter set");
    end

    state_e        state_q;
    logic [DW-1:0] tx_data_q;
    logic [1:0]    tx_ctrl_q;
    logic          tx_go_q, busy_q, done_q;
    logic [15:0]   tx_count_q, rx_count_q, err_count_q;
    logic [DW-1:0] shadow_q, wr_k_q, rx_data_q;
    logic [15:0]   lfsr_q;
    logic          rx_valid_q, rx_valid_qq;

    logic [1:0]    cmd_ctrl_d;
    logic [DW-1:0] cmd_data_d, lfsr_data;
    logic [15:0]   lfsr_d;
    logic [31:0]   tx_count_ext;
    logic          push, rx_edge, fifo_push, fifo_pop, err_inc, wd_fire;
    logic          fifo_full, fifo_empty;
    logic [DW-1:0] fifo_head;

    if (DW <= 14) begin : g_lfsr_narrow
        assign lfsr_data = lfsr_q[DW+1:2];
    end else begin : g_lfsr_wide
        assign lfsr_data = {{(DW-14){1'b0}}, lfsr_q[15:2]};
    end

    assign lfsr_d       = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    assign tx_count_ext = {16'd0, tx_count_q};

    always_comb begin
        cmd_ctrl_d = CTRL_READ;
        cmd_data_d = wr_k_q;
        if (MODE == 1) begin
            cmd_ctrl_d = (lfsr_q[1:0] == 2'b11) ? CTRL_READ : lfsr_q[1:0];
            cmd_data_d = lfsr_data;
        end else if (!tx_count_q[0] && (tx_count_ext != NUM_TOK_U - 32'd1)) begin
            cmd_ctrl_d = CTRL_WRITE;
        end
    end

    // An edge arriving while the FIFO is empty but a push is in flight is
    // checked against the pushed value and neither side touches the FIFO.
    assign push      = (state_q == ST_WAIT_ACK) && tx_ack && cmd_reads(tx_ctrl_q);
    assign rx_edge   = rx_valid_q && !rx_valid_qq;
    assign fifo_pop  = rx_edge && !fifo_empty;
    assign fifo_push = push && !(rx_edge && fifo_empty);
    assign err_inc   = rx_edge && (fifo_empty ? (!push || (rx_data_q != shadow_q))
                                              : (rx_data_q != fifo_head));

    e1of4_tester_exp_fifo #(
        .DW    (DW),
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .push_i      (fifo_push),
        .push_data_i (shadow_q),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef TESTER_TIMEOUT_EN
    logic        tx_ack_q;
    logic [31:0] wd_q;
    logic        timeout_q;
    logic        watching, activity;

    assign watching = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_REL) ||
                      (state_q == ST_DRAIN);
    assign activity = (tx_ack != tx_ack_q) || (rx_valid_q != rx_valid_qq);
    assign wd_fire  = watching && !activity && (wd_q >= 32'(TIMEOUT - 1));
    assign timeout  = timeout_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_ack_q  <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            tx_ack_q <= tx_ack;
            if (!watching || activity) wd_q <= '0;
            else                       wd_q <= wd_q + 32'd1;
            if (wd_fire) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            tx_ctrl_q   <= CTRL_READ;
            tx_go_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
            shadow_q    <= DW'(INIT_VAL);
            wr_k_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            rx_valid_q  <= 1'b0;
            rx_valid_qq <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            rx_valid_q  <= rx_valid;
            rx_valid_qq <= rx_valid_q;
            rx_data_q   <= rx_data;
            if (rx_edge) rx_count_q <= rx_count_q + 16'd1;
            if (err_inc && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_ISSUE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        tx_count_q  <= '0;
                        rx_count_q  <= '0;
                        err_count_q <= '0;
                        wr_k_q      <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (!(cmd_reads(cmd_ctrl_d) && fifo_full)) begin
                        tx_data_q <= cmd_data_d;
                        tx_ctrl_q <= cmd_ctrl_d;
                        tx_go_q   <= 1'b1;
                        state_q   <= ST_WAIT_ACK;
                        if (MODE == 1) lfsr_q <= lfsr_d;
                        if (cmd_ctrl_d == CTRL_WRITE) wr_k_q <= wr_k_q + 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tx_ack) begin
                        tx_go_q    <= 1'b0;
                        tx_count_q <= tx_count_q + 16'd1;
                        if (tx_ctrl_q != CTRL_READ) shadow_q <= tx_data_q;
                        state_q    <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (!tx_ack) state_q <= (tx_count_ext < NUM_TOK_U) ? ST_ISSUE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (wd_fire) begin
                state_q <= ST_DONE;
                tx_go_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_ctrl   = tx_ctrl_q;
    assign tx_go     = tx_go_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;

endmodule

`default_nettype wire
